monitor: RTL
============

# monitor

Result checker directly downstream of the stimulus driver. Each cycle it takes the monitor-aligned operand pair from the driver (already delayed to match DUT latency) and the DUT result. It computes the expected result with a behavioural reference model and compares it against the DUT. It also keeps saturating pass/fail statistics and captures the first failing vector for readout.

## Interface
- WIDTH, 32, operand width; must match the driver.
- OP, 0, reference operation: 0 = unsigned add (compare low WIDTH+1 bits), 1 = unsigned multiply (compare all 2*WIDTH bits).
- WARMUP, 3, cycles discarded after each start; covers driver/DUT pipeline fill.
- CNT_W, 32, width of the statistic counters.

Ports:
- clk_dut  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- i_enable  in  1  level; 1 = run checking, 0 = stop.
- i_halt_on_err  in  1  1 = freeze in HALTED on first mismatch.
- i_clear  in  1  single-cycle pulse; clears counters and capture, keeps state.
- i_mon_a, i_mon_b  in  WIDTH  operands from the driver's monitor outputs.
- i_dut_res  in  2*WIDTH  DUT result, same-cycle aligned with i_mon_a/b.
- o_test_count  out  CNT_W  number of compared vectors, saturating.
- o_err_count  out  CNT_W  number of mismatches, saturating.
- o_fail_valid  out  1  sticky; first-fail capture holds data.
- o_fail_a, o_fail_b  out  WIDTH  operands of the first mismatch.
- o_fail_exp, o_fail_res  out  2*WIDTH  expected and actual result of the first mismatch.
- o_running  out  1  1 while in RUN.
- o_halted  out  1  1 while in HALTED.

## Operation
- States: IDLE, WARMUP, RUN, HALTED.
  - IDLE: entered on reset; moves to WARMUP when i_enable=1, and the warm-up counter loads WARMUP-1.
  - WARMUP: counter decrements each cycle. Move to RUN when it reaches 0. Return to IDLE if i_enable=0.
  - RUN: compare every cycle. Return to IDLE if i_enable=0. Move to HALTED on a mismatch when i_halt_on_err=1.
  - HALTED: no compares. Exits only to IDLE when i_enable=0.
- WARMUP=0 means WARMUP is skipped; IDLE moves straight to RUN.
- Expected value:
  - OP=0: zero-extended i_mon_a + i_mon_b, WIDTH+1 bits, upper result bits masked to 0 on both sides.
  - OP=1: full 2*WIDTH product.
- Compare stage is registered: operands, expected, actual and mismatch flag latch in stage 1; counters and capture update from stage 1.
- A vector is compared only if it was sampled in RUN. Stage 1 valid is killed on any exit from RUN, but the in-flight compare still retires.
- Counters saturate at all-ones and never wrap.
- First-fail capture loads only when o_fail_valid=0. It is then held until i_clear or reset.
- i_clear takes priority over a retiring compare in the same cycle: the retiring vector is dropped.
- Changing OP or WIDTH at runtime is not supported; both are elaboration-time only.

## Timing
- Reset values: all counters 0, o_fail_* 0, o_fail_valid 0, o_running 0, o_halted 0, state IDLE, stage 1 invalid.
- Latency: a vector present at edge N (in RUN) is reflected in o_test_count, o_err_count and capture after edge N+1.
- o_running and o_halted are decoded from the state register.
  - o_running rises at the WARMUP+1th edge after i_enable is sampled high.
  - o_halted rises one edge after the mismatch is sampled.
- Halt: the mismatching vector counts and captures. No later vector is compared.
- Reset mid-RUN discards stage 1 and clears everything at that edge.

## Structure
- Shared package `tb_pkg`:
  - OP encodings OP_ADD=0, OP_MUL=1.
  - State enum.
  - Helper function for the masked result width (WIDTH+1 or 2*WIDTH).
- Sub-module `monitor_ref_model`: purely combinational expected-result model, parameterised by WIDTH and OP, so it can be reused by other checkers.
- Everything else (FSM, compare register, counters, capture) stays in `monitor`.

## Test plan
- Pass run: WIDTH=8, OP=0, WARMUP=3, i_dut_res = a+b always. Run 100 RUN cycles, then drop i_enable. Expect o_test_count=100, o_err_count=0, o_fail_valid=0.
- Single fault: a=0xFF, b=0x01, res=0x000 instead of 0x100. Expect o_err_count=1, o_fail_a=0xFF, o_fail_b=0x01, o_fail_exp=0x100, o_fail_res=0x000.
- Halt: i_halt_on_err=1, mismatch on the 5th RUN vector. Expect o_halted=1 one edge later, counters frozen at test=5 and err=1 while i_enable stays high.
- Warm-up discard: bad results during the first 3 cycles after enable, good results afterwards. Expect o_err_count=0.
- Saturation and clear: CNT_W=4, 20 mismatches. Expect o_err_count=15. Then pulse i_clear in the same cycle as a retiring compare: both counters 0 and o_fail_valid=0 on the next cycle.
- Multiply: OP=1, a=0xFF, b=0xFF, res=0xFE01 must pass; res=0xFE00 must fail. Then assert reset in RUN: every output returns to 0 at that edge.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared definitions for the result checker: operation codes, checker states
// and the width of the compared result field.
package tb_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_MUL = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_HALTED
  } state_t;

  // Number of low result bits that carry information for a given operation.
  function automatic int res_width(input int width, input int op);
    return (op == OP_MUL) ? 2 * width : width + 1;
  endfunction

endpackage

// File: rtl/monitor_if.sv
// Control, operand/result and statistics bundle between a stimulus source and
// the monitor.
interface monitor_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);

  logic                 i_enable;
  logic                 i_halt_on_err;
  logic                 i_clear;
  logic [WIDTH-1:0]     i_mon_a;
  logic [WIDTH-1:0]     i_mon_b;
  logic [2*WIDTH-1:0]   i_dut_res;
  logic [CNT_W-1:0]     o_test_count;
  logic [CNT_W-1:0]     o_err_count;
  logic                 o_fail_valid;
  logic [WIDTH-1:0]     o_fail_a;
  logic [WIDTH-1:0]     o_fail_b;
  logic [2*WIDTH-1:0]   o_fail_exp;
  logic [2*WIDTH-1:0]   o_fail_res;
  logic                 o_running;
  logic                 o_halted;

  modport master (
    output i_enable, i_halt_on_err, i_clear, i_mon_a, i_mon_b, i_dut_res,
    input  o_test_count, o_err_count, o_fail_valid, o_fail_a, o_fail_b,
           o_fail_exp, o_fail_res, o_running, o_halted
  );

  modport slave (
    input  i_enable, i_halt_on_err, i_clear, i_mon_a, i_mon_b, i_dut_res,
    output o_test_count, o_err_count, o_fail_valid, o_fail_a, o_fail_b,
           o_fail_exp, o_fail_res, o_running, o_halted
  );

endinterface

// File: rtl/monitor_ref_model.sv
// Combinational expected-result model: zero-extended sum or full product of
// the two operands, always presented on 2*WIDTH bits.
module monitor_ref_model
  import tb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP    = OP_ADD
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] exp_res
);

  generate
    if (OP == OP_MUL) begin : g_mul
      assign exp_res = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end else begin : g_add
      assign exp_res = {{(WIDTH-1){1'b0}}, ({1'b0, a} + {1'b0, b})};
    end
  endgenerate

endmodule

// File: rtl/monitor.sv
// Result checker: compares DUT results against the reference model after a
// warm-up window, keeps saturating statistics and captures the first failure.
module monitor
  import tb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int OP     = OP_ADD,
  parameter int WARMUP = 3,
  parameter int CNT_W  = 32
) (
  input  logic     clk_dut,
  input  logic     reset,
  monitor_if.slave bus
);

  localparam int RES_W = res_width(WIDTH, OP);
  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
  // Shifting out the whole word leaves 0, so the subtraction yields all-ones.
  localparam logic [2*WIDTH-1:0] RES_MASK = (ONE << RES_W) - ONE;
  localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic [2*WIDTH-1:0] exp_c;

  logic               vld_p1, mis_p1;
  logic [WIDTH-1:0]   a_p1, b_p1;
  logic [2*WIDTH-1:0] exp_p1, res_p1;

  logic [CNT_W-1:0]   test_q, err_q;
  logic               fail_vld_q;
  logic [WIDTH-1:0]   fail_a_q, fail_b_q;
  logic [2*WIDTH-1:0] fail_exp_q, fail_res_q;

  monitor_ref_model #(.WIDTH(WIDTH), .OP(OP)) u_ref (
    .a       (bus.i_mon_a),
    .b       (bus.i_mon_b),
    .exp_res (exp_c)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_enable) begin
          if (WARMUP == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WARMUP;
            wcnt_d  = WC_W'(WARMUP - 1);
          end
        end
      end
      ST_WARMUP: begin
        if (!bus.i_enable)     state_d = ST_IDLE;
        else if (wcnt_q == '0) state_d = ST_RUN;
        else                   wcnt_d  = wcnt_q - WC_W'(1);
      end
      ST_RUN: begin
        if (!bus.i_enable)                                   state_d = ST_IDLE;
        else if (bus.i_halt_on_err && vld_p1 && mis_p1)      state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!bus.i_enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_dut) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Stage 1: latch operands, expected, actual and mismatch flag
  always_ff @(posedge clk_dut) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      mis_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      exp_p1 <= '0;
      res_p1 <= '0;
    end else begin
      vld_p1 <= (state_q == ST_RUN) && (state_d == ST_RUN);
      mis_p1 <= (exp_c & RES_MASK) != (bus.i_dut_res & RES_MASK);
      a_p1   <= bus.i_mon_a;
      b_p1   <= bus.i_mon_b;
      exp_p1 <= exp_c & RES_MASK;
      res_p1 <= bus.i_dut_res & RES_MASK;
    end
  end

  // Stage 2: retire stage 1 into statistics and first-fail capture
  always_ff @(posedge clk_dut) begin
    if (reset || bus.i_clear) begin
      test_q     <= '0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_exp_q <= '0;
      fail_res_q <= '0;
    end else if (vld_p1) begin
      test_q <= sat_inc(test_q);
      if (mis_p1) begin
        err_q <= sat_inc(err_q);
        if (!fail_vld_q) begin
          fail_vld_q <= 1'b1;
          fail_a_q   <= a_p1;
          fail_b_q   <= b_p1;
          fail_exp_q <= exp_p1;
          fail_res_q <= res_p1;
        end
      end
    end
  end

  assign bus.o_test_count = test_q;
  assign bus.o_err_count  = err_q;
  assign bus.o_fail_valid = fail_vld_q;
  assign bus.o_fail_a     = fail_a_q;
  assign bus.o_fail_b     = fail_b_q;
  assign bus.o_fail_exp   = fail_exp_q;
  assign bus.o_fail_res   = fail_res_q;
  assign bus.o_running    = (state_q == ST_RUN);
  assign bus.o_halted     = (state_q == ST_HALTED);

endmodule
